// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: sequential fetch, immediate or stall-deferred branch redirect, BL link write.
// Optional taken-redirect counter enabled by defining TAKEN_BRANCH_CNT_EN.
module fetch_pc_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_if,
  input  logic              t_address,
  input  logic              bl_reg,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic [ADDR_W-1:0] branch_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              flush_ifid,
  output logic              lr_we,
  output logic [ADDR_W-1:0] lr_data,
`ifdef TAKEN_BRANCH_CNT_EN
  output logic [15:0]       taken_cnt,
`endif
  output logic              redirect_pending
);

  typedef enum logic {RUN, HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              lr_we_q, lr_we_d;
  logic [ADDR_W-1:0] lr_data_q, lr_data_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] hold_target_q, hold_target_d;
  logic              hold_bl_q, hold_bl_d;
  logic [ADDR_W-1:0] hold_link_q, hold_link_d;
  logic              redirect_c;

  logic [ADDR_W-1:0] inc_c;
  logic [ADDR_W-1:0] target_c;
  logic [ADDR_W-1:0] link_c;

  assign inc_c    = ADDR_W'(PC_INC);
  // Instructions are word aligned, so the low target bits are dropped.
  assign target_c = {target_addr[ADDR_W-1:2], 2'b00};
  assign link_c   = branch_pc + inc_c;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = 1'b0;
    lr_we_d       = 1'b0;
    lr_data_d     = lr_data_q;
    pend_d        = pend_q;
    hold_target_d = hold_target_q;
    hold_bl_d     = hold_bl_q;
    hold_link_d   = hold_link_q;
    redirect_c    = 1'b0;
    case (state_q)
      RUN: begin
        if (!stall_if) begin
          if (t_address) begin
            pc_d       = target_c;
            flush_d    = 1'b1;
            redirect_c = 1'b1;
            if (bl_reg) begin
              lr_we_d   = 1'b1;
              lr_data_d = link_c;
            end
          end else begin
            pc_d = pc_q + inc_c;
          end
        end else if (t_address) begin
          hold_target_d = target_c;
          hold_bl_d     = bl_reg;
          hold_link_d   = link_c;
          state_d       = HOLD;
          pend_d        = 1'b1;
        end
      end
      HOLD: begin
        // While stalled the same branch is re-presented, so inputs are ignored until release.
        if (!stall_if) begin
          pc_d       = hold_target_q;
          flush_d    = 1'b1;
          lr_we_d    = hold_bl_q;
          redirect_c = 1'b1;
          if (hold_bl_q) begin
            lr_data_d = hold_link_q;
          end
          state_d = RUN;
          pend_d  = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      lr_we_q       <= 1'b0;
      lr_data_q     <= '0;
      pend_q        <= 1'b0;
      hold_target_q <= '0;
      hold_bl_q     <= 1'b0;
      hold_link_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      lr_we_q       <= lr_we_d;
      lr_data_q     <= lr_data_d;
      pend_q        <= pend_d;
      hold_target_q <= hold_target_d;
      hold_bl_q     <= hold_bl_d;
      hold_link_q   <= hold_link_d;
    end
  end

`ifdef TAKEN_BRANCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (redirect_c && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_cnt = cnt_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect_c;
`endif

  assign pc               = pc_q;
  assign flush_ifid       = flush_q;
  assign lr_we            = lr_we_q;
  assign lr_data          = lr_data_q;
  assign redirect_pending = pend_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, redirects, deferred redirects, wrap and reset in HOLD.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall_if;
  logic        t_address;
  logic        bl_reg;
  logic [31:0] target_addr;
  logic [31:0] branch_pc;
  logic [31:0] pc;
  logic        flush_ifid;
  logic        lr_we;
  logic [31:0] lr_data;
  logic        redirect_pending;
`ifdef TAKEN_BRANCH_CNT_EN
  logic [15:0] taken_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall_if         (stall_if),
    .t_address        (t_address),
    .bl_reg           (bl_reg),
    .target_addr      (target_addr),
    .branch_pc        (branch_pc),
    .pc               (pc),
    .flush_ifid       (flush_ifid),
    .lr_we            (lr_we),
    .lr_data          (lr_data),
`ifdef TAKEN_BRANCH_CNT_EN
    .taken_cnt        (taken_cnt),
`endif
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic t, input logic b,
                       input logic [31:0] tgt, input logic [31:0] bpc);
    stall_if    = s;
    t_address   = t;
    bl_reg      = b;
    target_addr = tgt;
    branch_pc   = bpc;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_flush", {31'b0, flush_ifid}, 32'h0);
    check("rst_lrwe", {31'b0, lr_we}, 32'h0);
    check("rst_lrdata", lr_data, 32'h0);
    check("rst_pend", {31'b0, redirect_pending}, 32'h0);
    reset = 1'b0;
    #1;
    check("seq_pc0", pc, 32'h0);

    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("seq_pc%0d", i), pc, 32'(i * 4));
      check("seq_flush", {31'b0, flush_ifid}, 32'h0);
      check("seq_lrwe", {31'b0, lr_we}, 32'h0);
    end

    // plain branch from 0x10
    drive(0, 1, 0, 32'h100, 32'h8);
    step();
    check("br_pc", pc, 32'h100);
    check("br_flush", {31'b0, flush_ifid}, 32'h1);
    check("br_lrwe", {31'b0, lr_we}, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0);
    step();
    check("br_pc_next", pc, 32'h104);
    check("br_flush_off", {31'b0, flush_ifid}, 32'h0);

    // BL with unaligned target
    drive(0, 1, 1, 32'h203, 32'h40);
    step();
    check("bl_pc", pc, 32'h200);
    check("bl_lrwe", {31'b0, lr_we}, 32'h1);
    check("bl_lrdata", lr_data, 32'h44);
    check("bl_flush", {31'b0, flush_ifid}, 32'h1);
    drive(0, 0, 0, 32'h0, 32'h0);
    step();
    check("bl_pc_next", pc, 32'h204);
    check("bl_lrwe_off", {31'b0, lr_we}, 32'h0);
    check("bl_lrdata_keep", lr_data, 32'h44);

    // stall without branch just holds
    drive(1, 0, 0, 32'h0, 32'h0);
    step();
    check("stall_pc", pc, 32'h204);
    check("stall_pend", {31'b0, redirect_pending}, 32'h0);

    // deferred branch: 3 stalled cycles, target changed while in HOLD must be ignored
    drive(1, 1, 0, 32'h80, 32'h10);
    step();
    check("hold_pc1", pc, 32'h204);
    check("hold_pend1", {31'b0, redirect_pending}, 32'h1);
    drive(1, 1, 1, 32'h300, 32'h10);
    step();
    check("hold_pc2", pc, 32'h204);
    step();
    check("hold_pc3", pc, 32'h204);
    check("hold_pend3", {31'b0, redirect_pending}, 32'h1);
    check("hold_flush", {31'b0, flush_ifid}, 32'h0);
    drive(0, 1, 1, 32'h300, 32'h10);
    step();
    check("rel_pc", pc, 32'h80);
    check("rel_flush", {31'b0, flush_ifid}, 32'h1);
    check("rel_pend", {31'b0, redirect_pending}, 32'h0);
    check("rel_lrwe", {31'b0, lr_we}, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0);
    step();
    check("rel_pc_next", pc, 32'h84);
    check("rel_flush_off", {31'b0, flush_ifid}, 32'h0);

    // wrap-around of pc and link
    drive(0, 1, 0, 32'hFFFF_FFFC, 32'h0);
    step();
    check("wrap_pc_pre", pc, 32'hFFFF_FFFC);
    drive(0, 0, 0, 32'h0, 32'h0);
    step();
    check("wrap_pc", pc, 32'h0);
    drive(0, 1, 1, 32'h20, 32'hFFFF_FFFC);
    step();
    check("wrap_lrwe", {31'b0, lr_we}, 32'h1);
    check("wrap_lrdata", lr_data, 32'h0);
    check("wrap_pc_br", pc, 32'h20);

    // deferred BL delivers the latched link exactly once
    drive(1, 1, 1, 32'h400, 32'h60);
    step();
    check("dbl_lrwe_hold", {31'b0, lr_we}, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0);
    step();
    check("dbl_pc", pc, 32'h400);
    check("dbl_lrwe", {31'b0, lr_we}, 32'h1);
    check("dbl_lrdata", lr_data, 32'h64);
    step();
    check("dbl_lrwe_once", {31'b0, lr_we}, 32'h0);
`ifdef TAKEN_BRANCH_CNT_EN
    check("cnt_before_rst", {16'b0, taken_cnt}, 32'd6);
`endif

    // async reset while in HOLD
    drive(1, 1, 0, 32'h500, 32'h0);
    step();
    check("rh_pend_pre", {31'b0, redirect_pending}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rh_pc", pc, 32'h0);
    check("rh_pend", {31'b0, redirect_pending}, 32'h0);
    check("rh_lrdata", lr_data, 32'h0);
`ifdef TAKEN_BRANCH_CNT_EN
    check("rh_cnt", {16'b0, taken_cnt}, 32'd0);
`endif
    drive(0, 0, 0, 32'h0, 32'h0);
    #1;
    reset = 1'b0;
    step();
    check("rh_pc_after", pc, 32'h4);
    check("rh_flush_after", {31'b0, flush_ifid}, 32'h0);
    check("rh_lrwe_after", {31'b0, lr_we}, 32'h0);
    check("rh_pend_after", {31'b0, redirect_pending}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
